// File: rtl/lsu_ctrl.sv
// Load/store unit controller: turns one RV32I load/store request into word-wide memory
// read/write phases, doing read-modify-write for sub-word stores and sign/zero extension.
module lsu_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] virtual_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] data_in,
    input  logic [31:0] data_out,
    input  logic        mem_ready
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WR   = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] WAIT_MAX = CW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    state_q, state_d;
    logic          we_q, we_d;
    logic [2:0]    f3_q, f3_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   word_q, word_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic        illegal, misalign;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_val, merged;

    always_comb begin
        if (req_we) illegal = (req_funct3 >= 3'd3);
        else        illegal = (req_funct3 == 3'd3) || (req_funct3[2:1] == 2'b11);
        misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    end

    always_comb begin
        rd_byte = data_out[{addr_q[1:0], 3'b000} +: 8];
        rd_half = addr_q[1] ? data_out[31:16] : data_out[15:0];
        case (f3_q)
            3'd0:    load_val = {{24{rd_byte[7]}}, rd_byte};
            3'd1:    load_val = {{16{rd_half[15]}}, rd_half};
            3'd2:    load_val = data_out;
            3'd4:    load_val = {24'd0, rd_byte};
            3'd5:    load_val = {16'd0, rd_half};
            default: load_val = 32'd0;
        endcase
    end

    // Sub-word stores patch the word captured during the RD phase.
    always_comb begin
        merged = word_q;
        case (f3_q[1:0])
            2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        word_d  = word_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    if (illegal || misalign) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else if (req_we && (req_funct3 == 3'd2)) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                if (mem_ready) begin
                    cnt_d = '0;
                    if (!we_q) begin
                        rdata_d = load_val;
                        state_d = RESP;
                    end else begin
                        word_d  = data_out;
                        state_d = WR;
                    end
                end else if (cnt_q == WAIT_MAX) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WR: begin
                if (mem_ready) begin
                    state_d = RESP;
                end else if (cnt_q == WAIT_MAX) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            word_q  <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            word_q  <= word_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are gated by rst so they read zero throughout reset, not just after the edge.
    always_comb begin
        req_ready    = (state_q == IDLE) && !rst;
        mem_read     = (state_q == RD) && !rst;
        mem_write    = (state_q == WR) && !rst;
        resp_valid   = (state_q == RESP) && !rst;
        resp_err     = resp_valid && err_q;
        resp_rdata   = resp_valid ? rdata_q : 32'd0;
        virtual_addr = rst ? 32'd0 : {2'b00, addr_q[31:2]};
        data_in      = mem_write ? merged : 32'd0;
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a word-addressed memory model of configurable wait states.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] virtual_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        mem_ready;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem [64];
    int          wait_cnt = 0;
    int          ready_delay = 0;
    bit          ready_block = 1'b0;
    logic        poke_en = 1'b0;
    logic [5:0]  poke_idx = 6'd0;
    logic [31:0] poke_val = 32'd0;

    always #5 clk = ~clk;

    lsu_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .virtual_addr(virtual_addr), .mem_read(mem_read), .mem_write(mem_write),
        .data_in(data_in), .data_out(data_out), .mem_ready(mem_ready)
    );

    assign mem_ready = (mem_read || mem_write) && !ready_block && (wait_cnt >= ready_delay);
    assign data_out  = mem[virtual_addr[5:0]];

    always @(posedge clk) begin
        if (poke_en) mem[poke_idx] <= poke_val;
        if (mem_write && mem_ready) mem[virtual_addr[5:0]] <= data_in;
        if ((mem_read || mem_write) && !mem_ready) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    task automatic poke(input logic [5:0] idx, input logic [31:0] val);
        @(negedge clk);
        poke_en = 1'b1; poke_idx = idx; poke_val = val;
        @(posedge clk);
        #1 poke_en = 1'b0;
    endtask

    // Issues one request, scrambles the request inputs after acceptance and observes to completion.
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, output int lat, output logic [31:0] rdata,
                           output logic err, output int rd_cyc, output int wr_cyc,
                           output logic [31:0] wr_data, output logic [31:0] vaddr,
                           output logic bad);
        lat = 0; rdata = 32'd0; err = 1'b0; rd_cyc = 0; wr_cyc = 0;
        wr_data = 32'd0; vaddr = 32'd0; bad = 1'b0;
        @(negedge clk);
        if (!req_ready) bad = 1'b1;
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = ~we; req_funct3 = 3'd7;
        req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            @(negedge clk);
            if (mem_read && mem_write) bad = 1'b1;
            if (req_ready) bad = 1'b1;
            if (mem_read) begin
                rd_cyc++;
                vaddr = virtual_addr;
            end
            if (mem_write) begin
                wr_cyc++;
                if (wr_cyc > 1 && data_in != wr_data) bad = 1'b1;
                wr_data = data_in;
                vaddr = virtual_addr;
            end
            if (resp_valid) begin
                lat = n; rdata = resp_rdata; err = resp_err;
            end
        end
        if (lat != 0) begin
            @(negedge clk);
            if (resp_valid || !req_ready) bad = 1'b1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({req_ready, resp_valid, resp_err, mem_read, mem_write} !== 5'b0 ||
            resp_rdata !== 32'd0 || virtual_addr !== 32'd0 || data_in !== 32'd0) begin
            fails++;
            $display("FAIL reset_outputs: ready=%b rv=%b err=%b rd=%b wr=%b rdata=%h va=%h di=%h, required all 0",
                     req_ready, resp_valid, resp_err, mem_read, mem_write, resp_rdata,
                     virtual_addr, data_in);
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || virtual_addr !== 32'd0) begin
            fails++;
            $display("FAIL reset_release: ready=%b rv=%b va=%h, required 1 0 0",
                     req_ready, resp_valid, virtual_addr);
        end
    endtask

    task automatic test_sw_lw();
        int lat, rdc, wrc; logic [31:0] rdata, wd, va; logic err, bad;
        run_txn(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, lat, rdata, err, rdc, wrc, wd, va, bad);
        tests++;
        if (lat !== 2 || err !== 1'b0 || rdc !== 0 || wrc !== 1 || bad !== 1'b0) begin
            fails++;
            $display("FAIL sw_flow: lat=%0d err=%b rd=%0d wr=%0d bad=%b, required 2 0 0 1 0",
                     lat, err, rdc, wrc, bad);
        end
        tests++;
        if (va !== 32'h4 || wd !== 32'hDEAD_BEEF || mem[4] !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL sw_data: va=%h data_in=%h mem=%h, required 4 deadbeef deadbeef",
                     va, wd, mem[4]);
        end
        run_txn(1'b0, 3'd2, 32'h10, 32'h0, lat, rdata, err, rdc, wrc, wd, va, bad);
        tests++;
        if (lat !== 2 || err !== 1'b0 || rdc !== 1 || wrc !== 0 || bad !== 1'b0 || va !== 32'h4) begin
            fails++;
            $display("FAIL lw_flow: lat=%0d err=%b rd=%0d wr=%0d bad=%b va=%h, required 2 0 1 0 0 4",
                     lat, err, rdc, wrc, bad, va);
        end
        tests++;
        if (rdata !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL lw_rdata: got %h required deadbeef", rdata);
        end
    endtask

    task automatic test_subword();
        int lat, rdc, wrc; logic [31:0] rdata, wd, va; logic err, bad;
        logic [2:0]  f3s [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
        logic [31:0] ads [4] = '{32'h13, 32'h13, 32'h12, 32'h12};
        logic [31:0] exp [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8022, 32'h0000_8022};
        poke(6'd4, 32'h1122_3344);
        run_txn(1'b1, 3'd0, 32'h13, 32'h80, lat, rdata, err, rdc, wrc, wd, va, bad);
        tests++;
        if (lat !== 3 || err !== 1'b0 || rdc !== 1 || wrc !== 1 || bad !== 1'b0) begin
            fails++;
            $display("FAIL sb_flow: lat=%0d err=%b rd=%0d wr=%0d bad=%b, required 3 0 1 1 0",
                     lat, err, rdc, wrc, bad);
        end
        tests++;
        if (wd !== 32'h8022_3344 || mem[4] !== 32'h8022_3344) begin
            fails++;
            $display("FAIL sb_data: data_in=%h mem=%h, required 80223344", wd, mem[4]);
        end
        for (int i = 0; i < 4; i++) begin
            run_txn(1'b0, f3s[i], ads[i], 32'h0, lat, rdata, err, rdc, wrc, wd, va, bad);
            tests++;
            if (rdata !== exp[i] || err !== 1'b0 || lat !== 2 || bad !== 1'b0) begin
                fails++;
                $display("FAIL load_ext%0d: rdata=%h err=%b lat=%0d bad=%b, required %h 0 2 0",
                         i, rdata, err, lat, bad, exp[i]);
            end
        end
    endtask

    task automatic test_errors();
        int lat, rdc, wrc; logic [31:0] rdata, wd, va; logic err, bad;
        logic        wes [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [2:0]  f3s [5] = '{3'd2, 3'd1, 3'd3, 3'd4, 3'd6};
        logic [31:0] ads [5] = '{32'h02, 32'h01, 32'h00, 32'h00, 32'h00};
        for (int i = 0; i < 5; i++) begin
            run_txn(wes[i], f3s[i], ads[i], 32'hFFFF_FFFF, lat, rdata, err, rdc, wrc, wd, va, bad);
            tests++;
            if (lat !== 1 || err !== 1'b1 || rdc !== 0 || wrc !== 0 || rdata !== 32'd0 ||
                bad !== 1'b0) begin
                fails++;
                $display("FAIL err%0d: lat=%0d err=%b rd=%0d wr=%0d rdata=%h bad=%b, required 1 1 0 0 0 0",
                         i, lat, err, rdc, wrc, rdata, bad);
            end
        end
    endtask

    task automatic test_timeout();
        int lat, rdc, wrc; logic [31:0] rdata, wd, va; logic err, bad;
        ready_block = 1'b1;
        run_txn(1'b0, 3'd1, 32'h20, 32'h0, lat, rdata, err, rdc, wrc, wd, va, bad);
        ready_block = 1'b0;
        tests++;
        if (rdc !== 16 || wrc !== 0 || lat !== 17 || bad !== 1'b0) begin
            fails++;
            $display("FAIL timeout_flow: rd=%0d wr=%0d lat=%0d bad=%b, required 16 0 17 0",
                     rdc, wrc, lat, bad);
        end
        tests++;
        if (err !== 1'b1 || rdata !== 32'd0) begin
            fails++;
            $display("FAIL timeout_resp: err=%b rdata=%h, required 1 0", err, rdata);
        end
    endtask

    task automatic test_reset_mid();
        int  rdc = 0;
        bit  saw_wr = 1'b0;
        bit  saw_resp = 1'b0;
        logic [31:0] wd = 32'd0;
        poke(6'd16, 32'hAAAA_5555);
        ready_delay = 3;
        @(negedge clk);
        req_we = 1'b1; req_funct3 = 3'd1; req_addr = 32'h40; req_wdata = 32'h1234;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int n = 0; n < 30 && !saw_wr; n++) begin
            @(negedge clk);
            if (mem_read) rdc++;
            if (resp_valid) saw_resp = 1'b1;
            if (mem_write) begin
                saw_wr = 1'b1;
                wd = data_in;
            end
        end
        tests++;
        if (!saw_wr || rdc !== 4 || wd !== 32'hAAAA_1234) begin
            fails++;
            $display("FAIL sh_delay: saw_wr=%b rd=%0d data_in=%h, required 1 4 aaaa1234",
                     saw_wr, rdc, wd);
        end
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if (mem_write !== 1'b0 || mem_read !== 1'b0 || resp_valid !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_drop: wr=%b rd=%b rv=%b, required 0 0 0",
                     mem_write, mem_read, resp_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        ready_delay = 0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (resp_valid) saw_resp = 1'b1;
            if (n == 0) begin
                tests++;
                if (req_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL rst_mid_ready: got %b required 1", req_ready);
                end
            end
        end
        tests++;
        if (saw_resp || mem[16] !== 32'hAAAA_5555) begin
            fails++;
            $display("FAIL rst_mid_noresp: saw_resp=%b mem=%h, required 0 aaaa5555",
                     saw_resp, mem[16]);
        end
    endtask

    initial begin
        test_reset();
        test_sw_lw();
        test_subword();
        test_errors();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
